// File: rtl/pwr_seq_ctrl.sv
// Power-domain sequencer for a retention/restore domain.
// Sleep: save -> isolate -> power off. Wake: power on -> settle -> release reset -> restore.
// Every output is a registered decode of the state, so it lags the state by one cycle.
// Optional build macro PWR_SEQ_TIMEOUT_EN adds a save/restore handshake watchdog and a
// sticky err_o flag; without it err_o is tied low.
module pwr_seq_ctrl #(
  parameter int unsigned IsoCycles     = 4,
  parameter int unsigned SettleCycles  = 16,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sleep_req_i,
  input  logic wake_req_i,
  input  logic save_done_i,
  input  logic restore_done_i,
  output logic save_start_o,
  output logic restore_start_o,
  output logic iso_en_o,
  output logic pwr_off_o,
  output logic dom_rst_o,
  output logic busy_o,
  output logic asleep_o,
  output logic err_o
);

  localparam int unsigned MaxIsoSettle = (IsoCycles > SettleCycles) ? IsoCycles : SettleCycles;
  localparam int unsigned MaxCycles    =
      (MaxIsoSettle > TimeoutCycles) ? MaxIsoSettle : TimeoutCycles;
  localparam int unsigned CntW         = $clog2(MaxCycles + 1);

  localparam logic [CntW-1:0] IsoLoad    = CntW'(IsoCycles - 1);
  localparam logic [CntW-1:0] SettleLoad = CntW'(SettleCycles - 1);

  typedef enum logic [2:0] {
    StActive,
    StSaveStart,
    StSaveWait,
    StIsoOn,
    StOff,
    StPwrUp,
    StRestoreStart,
    StRestoreWait
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            pend_wake_q;
  logic            save_start_q;
  logic            restore_start_q;
  logic            iso_en_q;
  logic            pwr_off_q;
  logic            dom_rst_q;
  logic            busy_q;
  logic            asleep_q;

`ifdef PWR_SEQ_TIMEOUT_EN
  localparam logic [CntW-1:0] TimeoutLoad = CntW'(TimeoutCycles - 1);

  logic [CntW-1:0] wdog_q;
  logic            err_q;
`endif

  // Sequencer: state transitions, counters and the registered decode of the current state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q         <= StActive;
      cnt_q           <= '0;
      pend_wake_q     <= 1'b0;
      save_start_q    <= 1'b0;
      restore_start_q <= 1'b0;
      iso_en_q        <= 1'b0;
      pwr_off_q       <= 1'b0;
      dom_rst_q       <= 1'b0;
      busy_q          <= 1'b0;
      asleep_q        <= 1'b0;
`ifdef PWR_SEQ_TIMEOUT_EN
      wdog_q          <= '0;
      err_q           <= 1'b0;
`endif
    end else begin
      save_start_q    <= 1'b0;
      restore_start_q <= 1'b0;
      iso_en_q        <= 1'b0;
      pwr_off_q       <= 1'b0;
      dom_rst_q       <= 1'b0;
      busy_q          <= 1'b0;
      asleep_q        <= 1'b0;

      case (state_q)
        StActive: begin
          // Wake is meaningless while powered; only sleep is acted on.
          if (sleep_req_i) begin
            state_q <= StSaveStart;
`ifdef PWR_SEQ_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
          end
        end

        StSaveStart: begin
          save_start_q <= 1'b1;
          busy_q       <= 1'b1;
          if (wake_req_i) pend_wake_q <= 1'b1;
          state_q      <= StSaveWait;
`ifdef PWR_SEQ_TIMEOUT_EN
          wdog_q       <= TimeoutLoad;
`endif
        end

        StSaveWait: begin
          busy_q <= 1'b1;
          if (wake_req_i) pend_wake_q <= 1'b1;
          if (save_done_i) begin
            state_q <= StIsoOn;
            cnt_q   <= IsoLoad;
          end
`ifdef PWR_SEQ_TIMEOUT_EN
          else if (wdog_q == '0) begin
            // Abandon the save: domain stays powered and any pending wake is moot.
            state_q     <= StActive;
            err_q       <= 1'b1;
            pend_wake_q <= 1'b0;
          end else begin
            wdog_q <= wdog_q - 1'b1;
          end
`endif
        end

        StIsoOn: begin
          iso_en_q <= 1'b1;
          busy_q   <= 1'b1;
          if (wake_req_i) pend_wake_q <= 1'b1;
          if (cnt_q == '0) begin
            state_q <= StOff;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        StOff: begin
          iso_en_q  <= 1'b1;
          pwr_off_q <= 1'b1;
          dom_rst_q <= 1'b1;
          asleep_q  <= 1'b1;
          if (wake_req_i || pend_wake_q) begin
            state_q     <= StPwrUp;
            cnt_q       <= SettleLoad;
            pend_wake_q <= 1'b0;
          end
        end

        StPwrUp: begin
          iso_en_q  <= 1'b1;
          dom_rst_q <= 1'b1;
          busy_q    <= 1'b1;
          if (cnt_q == '0) begin
            state_q <= StRestoreStart;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        StRestoreStart: begin
          iso_en_q        <= 1'b1;
          restore_start_q <= 1'b1;
          busy_q          <= 1'b1;
          state_q         <= StRestoreWait;
`ifdef PWR_SEQ_TIMEOUT_EN
          wdog_q          <= TimeoutLoad;
`endif
        end

        StRestoreWait: begin
          iso_en_q <= 1'b1;
          busy_q   <= 1'b1;
          if (restore_done_i) begin
            state_q <= StActive;
          end
`ifdef PWR_SEQ_TIMEOUT_EN
          else if (wdog_q == '0) begin
            state_q <= StActive;
            err_q   <= 1'b1;
          end else begin
            wdog_q <= wdog_q - 1'b1;
          end
`endif
        end

        default: state_q <= StActive;
      endcase
    end
  end

  assign save_start_o    = save_start_q;
  assign restore_start_o = restore_start_q;
  assign iso_en_o        = iso_en_q;
  assign pwr_off_o       = pwr_off_q;
  assign dom_rst_o       = dom_rst_q;
  assign busy_o          = busy_q;
  assign asleep_o        = asleep_q;

`ifdef PWR_SEQ_TIMEOUT_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Self-checking bench for pwr_seq_ctrl (ISO=4, SETTLE=16, TIMEOUT=8).
// Expected latencies/output words are queued when stimulus is applied and popped on measurement.
module tb_pwr_seq_ctrl;

  localparam int unsigned IsoC    = 4;
  localparam int unsigned SettleC = 16;
  localparam int unsigned ToC     = 8;

  // Bit positions in the packed output word.
  localparam int SS   = 7;
  localparam int RS   = 6;
  localparam int ISO  = 5;
  localparam int PO   = 4;
  localparam int DR   = 3;
  localparam int BUSY = 2;
  localparam int ASL  = 1;
  localparam int ERR  = 0;

  logic clk, rst_n, sleep_req, wake_req, save_done, restore_done;
  logic save_start, restore_start, iso_en, pwr_off, dom_rst, busy, asleep, err;
  logic [7:0] outs;

  int n_vec  = 0;
  int n_miss = 0;
  int          exp_q[$];
  logic [7:0]  exp_o_q[$];

  assign outs = {save_start, restore_start, iso_en, pwr_off, dom_rst, busy, asleep, err};

  pwr_seq_ctrl #(
    .IsoCycles    (IsoC),
    .SettleCycles (SettleC),
    .TimeoutCycles(ToC)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .sleep_req_i    (sleep_req),
    .wake_req_i     (wake_req),
    .save_done_i    (save_done),
    .restore_done_i (restore_done),
    .save_start_o   (save_start),
    .restore_start_o(restore_start),
    .iso_en_o       (iso_en),
    .pwr_off_o      (pwr_off),
    .dom_rst_o      (dom_rst),
    .busy_o         (busy),
    .asleep_o       (asleep),
    .err_o          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count negedges until outs[sel] reads val; -1 if the bound expires.
  task automatic wait_sig(input int sel, input logic val, input int maxc, output int n);
    n = 0;
    while (outs[sel] !== val && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (outs[sel] !== val) n = -1;
  endtask

  // Count negedges for which outs[sel] stays high, starting at a cycle where it is high.
  task automatic measure_width(input int sel, input int maxc, output int w);
    w = 0;
    while (outs[sel] === 1'b1 && w < maxc) begin
      @(negedge clk);
      w++;
    end
  endtask

  task automatic test_reset();
    logic [7:0] eo;
    exp_o_q.push_back(8'h00);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    eo = exp_o_q.pop_front();
    n_vec++;
    if (outs !== eo) begin
      n_miss++;
      $display("FAIL reset_outs: got %b want %b", outs, eo);
    end
    exp_o_q.push_back(8'h00);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    eo = exp_o_q.pop_front();
    n_vec++;
    if (outs !== eo) begin
      n_miss++;
      $display("FAIL idle_after_reset: got %b want %b", outs, eo);
    end
  endtask

  task automatic test_full_cycle();
    int n, w, e;
    logic [7:0] eo;
    exp_q.push_back(2);
    sleep_req = 1'b1;
    wait_sig(SS, 1'b1, 20, n);
    sleep_req = 1'b0;
    e = exp_q.pop_front(); n_vec++;
    if (n !== e) begin n_miss++; $display("FAIL save_start_latency: got %0d want %0d", n, e); end
    exp_q.push_back(1);
    measure_width(SS, 10, w);
    e = exp_q.pop_front(); n_vec++;
    if (w !== e) begin n_miss++; $display("FAIL save_start_width: got %0d want %0d", w, e); end
    exp_o_q.push_back(8'h04);
    repeat (3) @(negedge clk);
    eo = exp_o_q.pop_front(); n_vec++;
    if (outs !== eo) begin n_miss++; $display("FAIL save_wait_outs: got %b want %b", outs, eo); end
    exp_q.push_back(2);
    save_done = 1'b1;
    wait_sig(ISO, 1'b1, 20, n);
    e = exp_q.pop_front(); n_vec++;
    if (n !== e) begin n_miss++; $display("FAIL done_to_iso: got %0d want %0d", n, e); end
    exp_q.push_back(IsoC);
    wait_sig(PO, 1'b1, 40, n);
    save_done = 1'b0;
    e = exp_q.pop_front(); n_vec++;
    if (n !== e) begin n_miss++; $display("FAIL iso_to_pwr_off: got %0d want %0d", n, e); end
    exp_o_q.push_back(8'h3A);
    eo = exp_o_q.pop_front(); n_vec++;
    if (outs !== eo) begin n_miss++; $display("FAIL off_outs: got %b want %b", outs, eo); end
    exp_o_q.push_back(8'h3A);
    repeat (3) @(negedge clk);
    eo = exp_o_q.pop_front(); n_vec++;
    if (outs !== eo) begin n_miss++; $display("FAIL off_hold: got %b want %b", outs, eo); end
    exp_q.push_back(2);
    wake_req = 1'b1;
    wait_sig(PO, 1'b0, 20, n);
    wake_req = 1'b0;
    e = exp_q.pop_front(); n_vec++;
    if (n !== e) begin n_miss++; $display("FAIL wake_to_pwr_on: got %0d want %0d", n, e); end
    exp_o_q.push_back(8'h2C);
    eo = exp_o_q.pop_front(); n_vec++;
    if (outs !== eo) begin n_miss++; $display("FAIL pwr_up_outs: got %b want %b", outs, eo); end
    exp_q.push_back(SettleC);
    wait_sig(DR, 1'b0, 60, n);
    e = exp_q.pop_front(); n_vec++;
    if (n !== e) begin n_miss++; $display("FAIL settle_cycles: got %0d want %0d", n, e); end
    exp_q.push_back(1);
    measure_width(RS, 10, w);
    e = exp_q.pop_front(); n_vec++;
    if (w !== e) begin n_miss++; $display("FAIL restore_start_width: got %0d want %0d", w, e); end
    exp_q.push_back(2);
    restore_done = 1'b1;
    wait_sig(ISO, 1'b0, 20, n);
    restore_done = 1'b0;
    e = exp_q.pop_front(); n_vec++;
    if (n !== e) begin n_miss++; $display("FAIL restore_to_active: got %0d want %0d", n, e); end
    exp_o_q.push_back(8'h00);
    eo = exp_o_q.pop_front(); n_vec++;
    if (outs !== eo) begin n_miss++; $display("FAIL active_outs: got %b want %b", outs, eo); end
  endtask

  // Shared by the pending-wake scenarios: sleep already started with the given wake pattern.
  task automatic test_pending_wake(input bit simultaneous, input string tag);
    int n, w, e;
    logic [7:0] eo;
    exp_q.push_back(2);
    sleep_req = 1'b1;
    wake_req  = simultaneous;
    wait_sig(SS, 1'b1, 20, n);
    sleep_req = 1'b0;
    wake_req  = 1'b0;
    e = exp_q.pop_front(); n_vec++;
    if (n !== e) begin n_miss++; $display("FAIL %s_save_start: got %0d want %0d", tag, n, e); end
    if (!simultaneous) begin
      wake_req = 1'b1;
      @(negedge clk);
      wake_req = 1'b0;
    end
    // Done at this negedge: iso two cycles later, then ISO cycles to power-off.
    exp_q.push_back(2 + IsoC);
    save_done = 1'b1;
    wait_sig(PO, 1'b1, 40, n);
    save_done = 1'b0;
    e = exp_q.pop_front(); n_vec++;
    if (n !== e) begin n_miss++; $display("FAIL %s_done_to_off: got %0d want %0d", tag, n, e); end
    exp_q.push_back(1);
    measure_width(PO, 10, w);
    e = exp_q.pop_front(); n_vec++;
    if (w !== e) begin n_miss++; $display("FAIL %s_off_one_cycle: got %0d want %0d", tag, w, e); end
    exp_q.push_back(SettleC);
    wait_sig(DR, 1'b0, 60, n);
    e = exp_q.pop_front(); n_vec++;
    if (n !== e) begin n_miss++; $display("FAIL %s_settle: got %0d want %0d", tag, n, e); end
    exp_q.push_back(1);
    measure_width(RS, 10, w);
    e = exp_q.pop_front(); n_vec++;
    if (w !== e) begin n_miss++; $display("FAIL %s_restore_start: got %0d want %0d", tag, w, e); end
    exp_q.push_back(2);
    restore_done = 1'b1;
    wait_sig(ISO, 1'b0, 20, n);
    restore_done = 1'b0;
    e = exp_q.pop_front(); n_vec++;
    if (n !== e) begin n_miss++; $display("FAIL %s_to_active: got %0d want %0d", tag, n, e); end
    exp_o_q.push_back(8'h00);
    repeat (5) @(negedge clk);
    eo = exp_o_q.pop_front(); n_vec++;
    if (outs !== eo) begin n_miss++; $display("FAIL %s_stays_active: got %b want %b", tag, outs, eo); end
  endtask

  task automatic test_wake_in_active();
    logic [7:0] eo;
    exp_o_q.push_back(8'h00);
    wake_req = 1'b1;
    repeat (4) @(negedge clk);
    wake_req = 1'b0;
    eo = exp_o_q.pop_front(); n_vec++;
    if (outs !== eo) begin n_miss++; $display("FAIL wake_ignored_active: got %b want %b", outs, eo); end
  endtask

  task automatic test_reset_mid();
    int n, e;
    logic [7:0] eo;
    // Reset from OFF.
    exp_q.push_back(2 + 2 + IsoC);
    sleep_req = 1'b1;
    wait_sig(SS, 1'b1, 20, n);
    sleep_req = 1'b0;
    save_done = 1'b1;
    wait_sig(PO, 1'b1, 40, e);
    save_done = 1'b0;
    n = n + e;
    e = exp_q.pop_front(); n_vec++;
    if (n !== e) begin n_miss++; $display("FAIL reach_off: got %0d want %0d", n, e); end
    exp_o_q.push_back(8'h00);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    eo = exp_o_q.pop_front(); n_vec++;
    if (outs !== eo) begin n_miss++; $display("FAIL reset_in_off: got %b want %b", outs, eo); end
    exp_o_q.push_back(8'h00);
    save_done = 1'b1;
    restore_done = 1'b1;
    repeat (3) @(negedge clk);
    save_done = 1'b0;
    restore_done = 1'b0;
    @(negedge clk);
    eo = exp_o_q.pop_front(); n_vec++;
    if (outs !== eo) begin n_miss++; $display("FAIL stray_done_after_off: got %b want %b", outs, eo); end
    // Reset from ISO_ON.
    exp_q.push_back(2 + 2);
    sleep_req = 1'b1;
    wait_sig(SS, 1'b1, 20, n);
    sleep_req = 1'b0;
    save_done = 1'b1;
    wait_sig(ISO, 1'b1, 20, e);
    save_done = 1'b0;
    n = n + e;
    e = exp_q.pop_front(); n_vec++;
    if (n !== e) begin n_miss++; $display("FAIL reach_iso_on: got %0d want %0d", n, e); end
    exp_o_q.push_back(8'h00);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    eo = exp_o_q.pop_front(); n_vec++;
    if (outs !== eo) begin n_miss++; $display("FAIL reset_in_iso_on: got %b want %b", outs, eo); end
    exp_o_q.push_back(8'h00);
    restore_done = 1'b1;
    @(negedge clk);
    restore_done = 1'b0;
    save_done = 1'b1;
    @(negedge clk);
    save_done = 1'b0;
    repeat (3) @(negedge clk);
    eo = exp_o_q.pop_front(); n_vec++;
    if (outs !== eo) begin n_miss++; $display("FAIL stray_done_after_iso: got %b want %b", outs, eo); end
  endtask

  task automatic test_random_invariants();
    logic ss_prev, rs_prev, po_prev, dr_prev;
    logic [4:0] viol;
    logic [7:0] eo;
    ss_prev = 1'b0; rs_prev = 1'b0; po_prev = 1'b0; dr_prev = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      viol[4] = (pwr_off || dom_rst) && !iso_en;
      viol[3] = ss_prev && save_start;
      viol[2] = rs_prev && restore_start;
      viol[1] = po_prev && dr_prev && !pwr_off && !dom_rst;
`ifdef PWR_SEQ_TIMEOUT_EN
      viol[0] = 1'b0;
`else
      viol[0] = err;
`endif
      n_vec++;
      if (viol !== 5'b0) begin
        n_miss++;
        $display("FAIL invariant cycle %0d: got %b want 00000", i, viol);
      end
      ss_prev = save_start; rs_prev = restore_start; po_prev = pwr_off; dr_prev = dom_rst;
      sleep_req    = ($urandom_range(0, 3) == 0);
      wake_req     = ($urandom_range(0, 3) == 0);
      save_done    = ($urandom_range(0, 2) == 0);
      restore_done = ($urandom_range(0, 2) == 0);
    end
    sleep_req = 1'b0; wake_req = 1'b0; save_done = 1'b0; restore_done = 1'b0;
    exp_o_q.push_back(8'h00);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    eo = exp_o_q.pop_front(); n_vec++;
    if (outs !== eo) begin n_miss++; $display("FAIL reset_after_random: got %b want %b", outs, eo); end
  endtask

`ifdef PWR_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int n, e;
    logic [7:0] eo;
    exp_q.push_back(2);
    sleep_req = 1'b1;
    wait_sig(SS, 1'b1, 20, n);
    sleep_req = 1'b0;
    e = exp_q.pop_front(); n_vec++;
    if (n !== e) begin n_miss++; $display("FAIL to_save_start: got %0d want %0d", n, e); end
    exp_q.push_back(ToC);
    wait_sig(ERR, 1'b1, 40, n);
    e = exp_q.pop_front(); n_vec++;
    if (n !== e) begin n_miss++; $display("FAIL timeout_err: got %0d want %0d", n, e); end
    exp_o_q.push_back(8'h01);
    @(negedge clk);
    eo = exp_o_q.pop_front(); n_vec++;
    if (outs !== eo) begin n_miss++; $display("FAIL after_timeout: got %b want %b", outs, eo); end
    exp_q.push_back(1);
    sleep_req = 1'b1;
    wait_sig(ERR, 1'b0, 10, n);
    e = exp_q.pop_front(); n_vec++;
    if (n !== e) begin n_miss++; $display("FAIL err_clear: got %0d want %0d", n, e); end
    exp_q.push_back(1);
    wait_sig(SS, 1'b1, 10, n);
    sleep_req = 1'b0;
    e = exp_q.pop_front(); n_vec++;
    if (n !== e) begin n_miss++; $display("FAIL to_save_start2: got %0d want %0d", n, e); end
    // Done lands in the final watchdog cycle and must win.
    exp_q.push_back(2);
    repeat (ToC - 1) @(negedge clk);
    save_done = 1'b1;
    wait_sig(ISO, 1'b1, 20, n);
    save_done = 1'b0;
    e = exp_q.pop_front(); n_vec++;
    if (n !== e) begin n_miss++; $display("FAIL done_at_expiry: got %0d want %0d", n, e); end
    exp_o_q.push_back(8'h00);
    eo = exp_o_q.pop_front(); n_vec++;
    if ({7'b0, err} !== eo) begin n_miss++; $display("FAIL no_err_at_expiry: got %b want %b", err, eo[0]); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    rst_n = 1'b0; sleep_req = 1'b0; wake_req = 1'b0; save_done = 1'b0; restore_done = 1'b0;
    @(negedge clk);
    test_reset();
    test_full_cycle();
    test_pending_wake(1'b0, "wake_in_save");
    test_pending_wake(1'b1, "sleep_and_wake");
    test_wake_in_active();
    test_reset_mid();
    test_random_invariants();
`ifdef PWR_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish want finish before 500000ns");
    $fatal(1, "bench timed out");
  end

endmodule
